// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction-memory port, redirect input, decode handshake, fault report
//
// Signals (directions as seen from the fetch unit, modport master):
//   imem_rd_addr   out  byte address of the fetch request
//   imem_rd_en     out  fetch request this cycle (memory always accepts)
//   imem_rd_data   in   word for the request issued in the previous cycle
//   redirect_valid in   load a new PC this cycle
//   redirect_pc    in   redirect target
//   instr_valid    out  FIFO head valid
//   instr_ready    in   decode accepts the head
//   instr          out  head instruction word
//   instr_pc       out  PC of the head instruction
//   fault_valid    out  misaligned-redirect fault pending
//   fault_pc       out  offending redirect target
// The slave modport is the memory/decode/branch side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_rd_addr;
    logic            imem_rd_en;
    logic [XLEN-1:0] imem_rd_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            fault_valid;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output imem_rd_addr, imem_rd_en,
        input  imem_rd_data,
        input  redirect_valid, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, instr_pc, fault_valid, fault_pc
    );

    modport slave (
        input  imem_rd_addr, imem_rd_en,
        output imem_rd_data,
        output redirect_valid, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, instr_pc, fault_valid, fault_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, 1-cycle imem fetch, instruction FIFO, redirect/fault handling
//
// Ports:
//   clk      clock, all state updates on posedge
//   cpu_rst  asynchronous active-high reset
//   bus      fetch_unit_if.master (imem port, redirect, decode handshake, fault report)
// Parameters:
//   XLEN     data/address width
//   RESET_PC PC loaded on reset
//   QDEPTH   instruction FIFO entries (power of two, >= 2)
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          cpu_rst,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] q_data [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic            fault_valid_r;
    logic [XLEN-1:0] fault_pc_r;

    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CW:0]     occupancy;

    // Credit check counts the in-flight fetch as already occupying a slot,
    // so a returning word always finds room in the FIFO.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue      = !cpu_rst && (state == ST_RUN) && !bus.redirect_valid
                        && (occupancy < (CW+1)'(QDEPTH));
    assign head_valid = (state == ST_RUN) && (count != '0);
    assign push       = inflight && !bus.redirect_valid;
    assign pop        = head_valid && bus.instr_ready;

    assign bus.imem_rd_en   = issue;
    assign bus.imem_rd_addr = pc;
    assign bus.instr_valid  = head_valid;
    assign bus.instr        = q_data[rd_ptr];
    assign bus.instr_pc     = q_pc[rd_ptr];
    assign bus.fault_valid  = fault_valid_r;
    assign bus.fault_pc     = fault_pc_r;

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            inflight_pc   <= '0;
            inflight      <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fault_valid_r <= 1'b0;
            fault_pc_r    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Redirect wins over everything: flush queue, drop the word
            // returning this cycle, no issue this cycle.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                pc            <= bus.redirect_pc;
                state         <= ST_RUN;
                fault_valid_r <= 1'b0;
            end else begin
                state         <= ST_FAULT;
                fault_valid_r <= 1'b1;
                fault_pc_r    <= bus.redirect_pc;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
            if (push) begin
                q_data[wr_ptr] <= bus.imem_rd_data;
                q_pc[wr_ptr]   <= inflight_pc;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized ready/redirect traffic
module tb_fetch_unit;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic cpu_rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk     (clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_pc = RESET_PC;
    logic        m_fault = 1'b0;
    logic [31:0] m_fault_pc = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        popped = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive memory data and inputs at negedge, then check the
    // issue decision and advance the reference model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic r);
        logic exp_en;
        @(negedge clk);
        cyc++;
        bus.imem_rd_data   = pend ? mem_word(pend_addr) : $urandom;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        cpu_rst            = r;
        #2;
        // outstanding work = queue entries before this cycle's pop
        exp_en = !r && !m_fault && !rv && ((q.size() + int'(popped)) < QDEPTH);
        check("imem_rd_en", {31'b0, bus.imem_rd_en}, {31'b0, exp_en});
        if (exp_en) check("imem_rd_addr", bus.imem_rd_addr, m_pc);
        pend      = bus.imem_rd_en;
        pend_addr = bus.imem_rd_addr;
        if (exp_en) begin
            q.push_back('{pc: m_pc, data: mem_word(m_pc), cyc: cyc});
            m_pc = m_pc + 32'd4;
        end
        if (q.size() > QDEPTH) check("fifo_overflow", q.size(), QDEPTH);
        if (rv) begin
            q.delete();
            if (rpc[1:0] == 2'b00) begin
                m_pc    = rpc;
                m_fault = 1'b0;
            end else begin
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end
        end
        if (r) begin
            q.delete();
            m_pc    = RESET_PC;
            m_fault = 1'b0;
            pend    = 1'b0;
        end
    endtask

    // Monitor: compares the decode-side outputs against the scoreboard head.
    always @(negedge clk) begin
        logic exp_valid;
        #1;
        popped    = 1'b0;
        exp_valid = 1'b0;
        if (!cpu_rst && !m_fault && q.size() > 0)
            exp_valid = (cyc - q[0].cyc) >= 2;
        check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, exp_valid});
        if (bus.instr_valid && exp_valid) begin
            check("instr_pc", bus.instr_pc, q[0].pc);
            check("instr", bus.instr, q[0].data);
            if (bus.instr_ready) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
        end
        check("fault_valid", {31'b0, bus.fault_valid}, {31'b0, !cpu_rst && m_fault});
        if (cpu_rst) begin
            check("fault_pc_rst", bus.fault_pc, 32'h0);
            check("instr_rst", bus.instr, 32'h0);
            check("instr_pc_rst", bus.instr_pc, 32'h0);
        end else if (m_fault) begin
            check("fault_pc", bus.fault_pc, m_fault_pc);
        end
    end

    initial begin
        logic [31:0] tgt;
        bus.imem_rd_data   = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // reset, then streaming with ready held high
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0);

        // ready low from reset: credit limit, then drain and resume
        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);

        // redirect with 3 queued entries plus one in flight
        step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

        // redirect in the same cycle as a pop
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

        // misaligned redirect holds the unit in FAULT until an aligned one
        step(1'b1, 1'b1, 32'h0000_0102, 1'b0);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0203, 1'b0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

        // asynchronous reset with the FIFO full
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
        #1 cpu_rst = 1'b1;
        #1;
        check("async_rd_en", {31'b0, bus.imem_rd_en}, 32'h0);
        check("async_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("async_instr", bus.instr, 32'h0);
        check("async_instr_pc", bus.instr_pc, 32'h0);
        check("async_addr", bus.imem_rd_addr, RESET_PC);
        q.delete();
        m_pc    = RESET_PC;
        m_fault = 1'b0;
        pend    = 1'b0;
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap past 0xFFFF_FFFC
        step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, tgt, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting between the PC/instruction-memory port and the decoder.
- Owns the PC and issues one word-fetch per cycle to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects: flushes the FIFO and squashes any in-flight fetch. Flags misaligned redirect targets.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QDEPTH, 4, instruction FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- cpu_rst  in  1  asynchronous, active-high reset.
- imem_rd_addr  out  XLEN  byte address of fetch request.
- imem_rd_en  out  1  fetch request this cycle; memory always accepts.
- imem_rd_data  in  XLEN  word for the request issued in the previous cycle.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  XLEN  redirect target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  XLEN  head instruction word.
- instr_pc  out  XLEN  PC of head instruction.
- fault_valid  out  1  misaligned-redirect fault pending.
- fault_pc  out  XLEN  offending target address.

Behaviour:
- Reset, asynchronous while cpu_rst=1:
  - pc=RESET_PC; FIFO empty; inflight=0; state=RUN.
  - imem_rd_en=0, instr_valid=0, fault_valid=0, fault_pc=0, instr/instr_pc=0.
  - Reset asserted mid-operation discards all queued and in-flight words immediately.
- States:
  - RUN: normal fetching.
  - FAULT: fetching halted, fault_valid=1.
- Issue rule, combinational: imem_rd_en = (state==RUN) && !redirect_valid && (count + inflight < QDEPTH). imem_rd_addr = pc.
  - When imem_rd_en=1: pc <= pc+4 (mod 2^XLEN, wraps silently) and inflight <= 1 next cycle. Otherwise inflight <= 0.
- Response: in the cycle after an issue with inflight=1 and no redirect this cycle, push {imem_rd_data, issued pc} into the FIFO.
- Latency: request at cycle N, data sampled at N+1, instr_valid at N+2 at the earliest. There is no bypass.
- Throughput: one instruction per cycle sustained when instr_ready is held at 1.
- Pop: occurs when instr_valid && instr_ready. Simultaneous push and pop keeps count unchanged. Credit accounting guarantees a push never hits a full FIFO; the bench asserts this never happens.
- instr/instr_pc are driven from the FIFO head, are registered, and are stable while instr_valid && !instr_ready.
- Redirect, highest priority over push, pop and issue:
  - Flush the FIFO (count <= 0), clear inflight, drop the response arriving this cycle. No request is issued this cycle.
  - If redirect_pc[1:0]==0: pc <= redirect_pc, state <= RUN, fault_valid <= 0. The first request at redirect_pc occurs the next cycle.
  - Else: state <= FAULT, fault_valid <= 1, fault_pc <= redirect_pc, pc unchanged.
- FAULT:
  - imem_rd_en=0 and instr_valid=0.
  - Held until a redirect arrives.
  - An aligned redirect returns to RUN.
  - A misaligned redirect stays in FAULT and updates fault_pc.
- No other transitions exist. Widths: count is $clog2(QDEPTH)+1 bits.

Test Plan:
- Reset release with instr_ready=1 and memory word[a]=a:
  - imem_rd_addr 0,4,8,... on consecutive cycles.
  - instr_valid first high 2 cycles after the first request.
  - instr_pc 0,4,8 back-to-back with instr==instr_pc.
- instr_ready=0 from reset:
  - Exactly 4 requests issued (0,4,8,12), then imem_rd_en=0.
  - Head stays instr_pc=0.
  - Raise ready: pops 0,4,8,12 with fetching resuming at 16 without gaps or duplicates.
- Redirect to 0x100 while FIFO holds 3 entries and a fetch is in flight:
  - Next cycle instr_valid=0, imem_rd_en=1 with imem_rd_addr=0x100.
  - Next instr_pc seen is 0x100; no stale PCs appear.
- Redirect asserted in the same cycle as instr_valid&&instr_ready:
  - The popped entry is the only one consumed.
  - All others are dropped; the next instr_pc equals the target.
- Redirect to 0x102:
  - fault_valid=1, fault_pc=0x102, imem_rd_en and instr_valid stay 0 for 10 cycles.
  - Redirect to 0x200 clears fault_valid and fetches from 0x200.
- cpu_rst pulsed asynchronously mid-stream with the FIFO full:
  - Outputs zero immediately without waiting for a clock edge.
  - After release, fetching restarts at RESET_PC.
- PC at 0xFFFF_FFFC: the next request address is 0x0000_0000.
